// File: rtl/proc_check_pkg.sv
// Shared definitions for the processor self-check monitors: verdict state
// encoding and the default pass/scratch constants used by existing benches.
package proc_check_pkg;

    typedef enum logic [1:0] {
        CHK_RUN     = 2'd0,
        CHK_PASS    = 2'd1,
        CHK_FAIL    = 2'd2,
        CHK_TIMEOUT = 2'd3
    } chk_state_e;

    localparam int unsigned DEF_PASS_ADDR = 100;
    localparam int unsigned DEF_PASS_DATA = 25;
    localparam int unsigned DEF_IGN_BASE  = 96;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // count up on inc, hold at the maximum value, zero on clr or reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mem_write_checker.sv
// Data-memory write monitor: latches PASS on the expected write, FAIL on a
// bad write (with its address/data), or TIMEOUT when no verdict arrives in
// the cycle budget. Verdict states are terminal until reset or clear.
module mem_write_checker
    import proc_check_pkg::*;
#(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter logic [ADDR_W-1:0]  PASS_ADDR   = ADDR_W'(DEF_PASS_ADDR),
    parameter logic [DATA_W-1:0]  PASS_DATA   = DATA_W'(DEF_PASS_DATA),
    parameter logic [ADDR_W-1:0]  IGN_BASE    = ADDR_W'(DEF_IGN_BASE),
    parameter int unsigned        IGN_SIZE    = 1,
    parameter int unsigned        TIMEOUT_CYC = 1000,
    parameter int                 CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  write_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    // Window bounds carry one extra bit so BASE+SIZE never wraps around.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, IGN_BASE};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(IGN_SIZE);
    localparam logic [63:0]     TO_LAST = 64'(TIMEOUT_CYC) - 64'd1;

    chk_state_e state;
    logic       run;
    logic       wr;
    logic       at_pass;
    logic       in_win;
    logic       good_wr;
    logic       bad_wr;
    logic       to_hit;

    assign run     = (state == CHK_RUN);
    assign wr      = run && MemWrite;
    assign at_pass = (DataAdr == PASS_ADDR);
    assign in_win  = (IGN_SIZE != 0) && ({1'b0, DataAdr} >= WIN_LO) &&
                     ({1'b0, DataAdr} < WIN_HI);
    assign good_wr = wr && at_pass && (WriteData == PASS_DATA);
    assign bad_wr  = wr && (at_pass ? (WriteData != PASS_DATA) : !in_win);
    // Budget expires on the edge where the RUN-cycle count shows TIMEOUT_CYC-1.
    assign to_hit  = (TIMEOUT_CYC != 0) && (64'(cycle_count) == TO_LAST);

    // verdict FSM: write decisions beat the timeout, clear beats everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CHK_RUN;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clear) begin
            state     <= CHK_RUN;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (good_wr) begin
            state     <= CHK_PASS;
        end else if (bad_wr) begin
            state     <= CHK_FAIL;
            fail_addr <= DataAdr;
            fail_data <= WriteData;
        end else if (run && to_hit) begin
            state     <= CHK_TIMEOUT;
        end
    end

    sat_counter #(.W(CNT_W)) u_write_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wr),
        .clr   (clear),
        .count (write_count)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (run),
        .clr   (clear),
        .count (cycle_count)
    );

    assign done    = !run;
    assign pass    = (state == CHK_PASS);
    assign fail    = (state == CHK_FAIL);
    assign timeout = (state == CHK_TIMEOUT);

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor for the single-cycle processor's data-memory write port, instantiated beside the core in simulation and FPGA bring-up.
- Watches MemWrite/DataAdr/WriteData. Declares PASS on a write of the expected value to the expected address, and FAIL on any write outside a permitted scratch window.
- Declares TIMEOUT if no verdict arrives within a cycle budget, and latches diagnostics for the failing write.
- Replaces fixed-constant, negedge-sampled bench checking with parametrised hardware usable on silicon (LED/status readout).

Parameters:
- ADDR_W, 32, width of the monitored address bus.
- DATA_W, 32, width of the monitored write-data bus.
- PASS_ADDR, 100, address whose write decides the verdict.
- PASS_DATA, 25, data value at PASS_ADDR that means success.
- IGN_BASE, 96, base of the tolerated scratch-write window.
- IGN_SIZE, 1, number of addresses in the window; 0 means no window.
- TIMEOUT_CYC, 1000, cycle budget for a verdict; 0 disables the timeout.
- CNT_W, 16, width of the write and cycle counters.

Ports:
- clk  in  1  system clock; all sampling on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart: returns the block to RUN and zeroes counters and diagnostics.
- MemWrite  in  1  write strobe from the core.
- DataAdr  in  ADDR_W  write address.
- WriteData  in  DATA_W  write data.
- done  out  1  a verdict is latched.
- pass  out  1  verdict is success.
- fail  out  1  verdict is a bad write, including a wrong value at PASS_ADDR.
- timeout  out  1  verdict is budget exhausted.
- write_count  out  CNT_W  accepted writes since reset/clear; saturates at all-ones.
- cycle_count  out  CNT_W  cycles spent in RUN; saturates at all-ones.
- fail_addr  out  ADDR_W  DataAdr of the write that caused FAIL; otherwise 0.
- fail_data  out  DATA_W  WriteData of the write that caused FAIL; otherwise 0.

Behaviour:
- Reset (reset=0, async): state=RUN, all outputs 0.
- States:
  - RUN: the only state that samples the bus.
  - PASS, FAIL, TIMEOUT: terminal; the state and all outputs hold.
- done = (state != RUN), registered. pass/fail/timeout are one-hot when done=1, all 0 in RUN.
- RUN, on each rising edge with MemWrite=1, in priority order:
  - DataAdr==PASS_ADDR and WriteData==PASS_DATA -> PASS.
  - DataAdr==PASS_ADDR and the data differs -> FAIL, latch address and data.
  - DataAdr in [IGN_BASE, IGN_BASE+IGN_SIZE) -> stay in RUN.
  - Otherwise -> FAIL, latch address and data.
- write_count increments on every MemWrite=1 edge in RUN, including the deciding write.
- Latency: the verdict is visible on outputs one cycle after the deciding edge (registered).
- Window comparison is unsigned and computed ADDR_W+1 bits wide, so IGN_BASE+IGN_SIZE cannot wrap.
- Timeout: cycle_count increments every RUN cycle. When TIMEOUT_CYC!=0 and cycle_count reaches TIMEOUT_CYC-1 with no decision that edge -> TIMEOUT.
- Simultaneous events:
  - A deciding write on the timeout edge wins; PASS/FAIL takes priority over TIMEOUT.
  - clear=1 overrides everything except reset, in any state.
- Terminal states ignore MemWrite entirely; no counter changes.
- Reset mid-run: immediate return to RUN with zeroed outputs, regardless of clock.
- MemWrite=0 cycles never change verdict logic; DataAdr/WriteData are don't-care then.
- Counter saturation never wraps and never triggers a verdict by itself.

Decomposition:
- Shared package proc_check_pkg holds:
  - state enum CHK_RUN/CHK_PASS/CHK_FAIL/CHK_TIMEOUT (2 bits);
  - default PASS_ADDR/PASS_DATA/IGN_BASE constants shared with existing benches.
- Sub-module sat_counter (parameter W; inputs inc, clr; output count) is used for both write_count and cycle_count.

Test Plan:
- Write 96<-7, then 100<-25 -> done=1, pass=1 the next cycle; write_count=2, fail_addr=0.
- Write 100<-24 -> fail=1, fail_addr=100, fail_data=24; later writes leave write_count=1.
- Write 40<-5 with IGN_SIZE=1 -> fail=1, fail_addr=40; with IGN_BASE=32, IGN_SIZE=16 it stays in RUN.
- TIMEOUT_CYC=10, no writes -> timeout=1 after exactly 10 RUN cycles. Repeat with 100<-25 on cycle 9 -> pass=1, timeout=0.
- Reach PASS, assert clear for 1 cycle -> all outputs 0, state RUN; then 100<-25 -> pass again.
- Drop reset asynchronously between edges during RUN with write_count=3 -> outputs 0 immediately. Release reset, write 100<-25 -> pass with write_count=1.
